// File: rtl/ysyx_23060020_mem_arb.sv
// rtl/ysyx_23060020_mem_arb.sv - round-robin IFU/LSU arbiter for the single memory port
//
// Purpose: accepts one request at a time from the instruction fetch unit
// (read-only) or the load/store unit, latches it into holding registers,
// forwards it to memory and routes the response back to the granted master.
// Ties go to the master that was not granted most recently.
//
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   ifu_req_valid/ready, ifu_addr    IFU read request channel
//   ifu_rsp_valid/ready, ifu_rdata   IFU read response channel
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen, lsu_wdata, lsu_wmask    LSU request channel
//   lsu_rsp_valid/ready, lsu_rdata   LSU response channel (read data or write ack)
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask    request to the memory slave (latched fields)
//   mem_rsp_valid/ready, mem_rdata   response from the memory slave
module ysyx_23060020_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int WMASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_q;       // 0 = IFU, 1 = LSU
  logic                 last_grant_q;  // master granted most recently
  logic [ADDR_W-1:0]    addr_q;
  logic                 wen_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [WMASK_W-1:0]   wmask_q;

  logic win_lsu;
  logic grant;
  logic rsp_hs;

  // LSU wins when it is the only requester, or on a tie when the IFU had the
  // previous grant. Depends only on master inputs and registered state, so
  // mem_req_ready never reaches the req_ready outputs.
  assign win_lsu = lsu_req_valid & (~ifu_req_valid | ~last_grant_q);

  // rst gating keeps both req_ready low while reset is held, even though the
  // state register already reads IDLE.
  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    mem_req_valid = 1'b0;
    state_d       = state_q;
    unique case (state_q)
      IDLE: begin
        ifu_req_ready = rst & ifu_req_valid & ~win_lsu;
        lsu_req_ready = rst & win_lsu;
        if (ifu_req_ready || lsu_req_ready) state_d = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        mem_rsp_ready = owner_q ? lsu_rsp_ready : ifu_rsp_ready;
        ifu_rsp_valid = ~owner_q & mem_rsp_valid;
        lsu_rsp_valid = owner_q & mem_rsp_valid;
        if (mem_rsp_valid && mem_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant  = ifu_req_ready | lsu_req_ready;
  assign rsp_hs = (state_q == WAIT) & mem_rsp_valid & mem_rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;  // IFU wins the first tie after reset
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= lsu_req_ready;
        // IFU requests are reads: write fields are forced to zero.
        addr_q  <= lsu_req_ready ? lsu_addr  : ifu_addr;
        wen_q   <= lsu_req_ready & lsu_wen;
        wdata_q <= lsu_req_ready ? lsu_wdata : '0;
        wmask_q <= lsu_req_ready ? lsu_wmask : '0;
      end
      if (rsp_hs) last_grant_q <= owner_q;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;

endmodule

// File: tb/tb_ysyx_23060020_mem_arb.sv
// tb/tb_ysyx_23060020_mem_arb.sv - directed self-checking bench for ysyx_23060020_mem_arb
module tb_ysyx_23060020_mem_arb;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  ysyx_23060020_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge; inputs are driven there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction with both masters requesting and an always-ready memory;
  // returns which master was granted (0 = IFU, 1 = LSU).
  task automatic rr_txn(output logic granted);
    #1;
    check("rr_one_ready", {63'd0, ifu_req_ready ^ lsu_req_ready}, 64'd1);
    granted = lsu_req_ready;
    step();
    mem_req_ready = 1'b1;
    #1;
    check("rr_mem_wen", {63'd0, mem_wen}, {63'd0, granted});
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    #1;
    check("rr_rsp_valid", {62'd0, lsu_rsp_valid, ifu_rsp_valid},
          granted ? 64'd2 : 64'd1);
    step();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    logic g;
    rst = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; ifu_rsp_ready = 1'b1;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; lsu_rsp_ready = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0;

    // Reset held with both masters requesting: everything quiet.
    step(); step();
    check("rst_ifu_req_ready", {63'd0, ifu_req_ready}, 64'd0);
    check("rst_lsu_req_ready", {63'd0, lsu_req_ready}, 64'd0);
    check("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("rst_mem_rsp_ready", {63'd0, mem_rsp_ready}, 64'd0);
    check("rst_rsp_valids", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);

    // Release: first tie goes to IFU. Cycle N.
    mem_rsp_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("first_ifu_ready", {63'd0, ifu_req_ready}, 64'd1);
    check("first_lsu_ready", {63'd0, lsu_req_ready}, 64'd0);
    step();
    // N+1: request at memory.
    mem_req_ready = 1'b1;
    #1;
    check("ifu_mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
    check("ifu_mem_addr", {32'd0, mem_addr}, 64'h8000_0000);
    check("ifu_mem_wen", {63'd0, mem_wen}, 64'd0);
    check("ifu_mem_wmask", {60'd0, mem_wmask}, 64'd0);
    check("busy_req_readys", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
    step();
    // N+2: response.
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0413;
    #1;
    check("ifu_rsp_valid", {63'd0, ifu_rsp_valid}, 64'd1);
    check("ifu_rdata", {32'd0, ifu_rdata}, 64'h0000_0413);
    check("ifu_lsu_rsp_quiet", {63'd0, lsu_rsp_valid}, 64'd0);
    check("ifu_mem_rsp_ready", {63'd0, mem_rsp_ready}, 64'd1);
    step();
    // N+3: IDLE again, pending LSU wins over still-valid IFU.
    mem_rsp_valid = 1'b0;
    #1;
    check("n3_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("lsu_wins_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
    step();

    // LSU write held in REQ for 3 cycles of memory back-pressure.
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wr_req_valid", {63'd0, mem_req_valid}, 64'd1);
      check("wr_fields", {mem_addr, mem_wdata}, 64'h8000_1000_DEAD_BEEF);
      check("wr_wen_wmask", {59'd0, mem_wen, mem_wmask}, 64'h1F);
      lsu_addr = 32'h1111_2222; lsu_wdata = 32'h0; lsu_wmask = 4'h1;
      step();
      lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
    #1;
    check("wr_ack", {62'd0, lsu_rsp_valid, ifu_rsp_valid}, 64'd2);
    step();
    mem_rsp_valid = 1'b0;

    // Round-robin with continuous requests: IFU, LSU, IFU, LSU, IFU, LSU.
    for (int i = 0; i < 6; i++) begin
      rr_txn(g);
      check("rr_order", {63'd0, g}, (i % 2 == 1) ? 64'd1 : 64'd0);
    end

    // Response back-pressure on an LSU read.
    ifu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'h8000_2000;
    #1;
    check("bp_lsu_grant", {63'd0, lsu_req_ready}, 64'd1);
    step();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; lsu_rsp_ready = 1'b0;
    mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_mem_rsp_ready", {63'd0, mem_rsp_ready}, 64'd0);
      check("bp_lsu_rsp_valid", {63'd0, lsu_rsp_valid}, 64'd1);
      check("bp_ifu_blocked", {63'd0, ifu_req_ready}, 64'd0);
      step();
    end
    lsu_rsp_ready = 1'b1;
    #1;
    check("bp_release", {31'd0, mem_rsp_ready, lsu_rdata}, 64'h1_CAFE_F00D);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("bp_ifu_after", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);

    // Reset in WAIT on an LSU read.
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000;
    #1;
    check("mid_lsu_grant", {63'd0, lsu_req_ready}, 64'd1);
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; lsu_rsp_ready = 1'b0;
    #1;
    check("mid_wait_valid", {63'd0, lsu_rsp_valid}, 64'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_rsp_valid", {63'd0, lsu_rsp_valid}, 64'd0);
    check("mid_rst_mem_rsp_ready", {63'd0, mem_rsp_ready}, 64'd0);
    check("mid_rst_addr", {32'd0, mem_addr}, 64'd0);
    step();
    rst = 1'b1; mem_rsp_valid = 1'b0; lsu_req_valid = 1'b0; lsu_rsp_ready = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
    #1;
    check("post_ifu_grant", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);
    step();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    check("post_mem_addr", {31'd0, mem_req_valid, mem_addr}, 64'h1_8000_0008);
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    check("post_ifu_rsp", {31'd0, ifu_rsp_valid, ifu_rdata}, 64'h1_1234_5678);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("post_idle", {62'd0, mem_req_valid, mem_rsp_ready}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
